// File: rtl/sample_iterator_if.sv
// Bus between the bbox stage (R13 side) and the hash stage (R14 side) for sample_iterator.
// master = upstream/downstream environment, slave = the iterator itself.
interface sample_iterator_if #(
    parameter int SIGFIG      = 24,
    parameter int VERTS       = 3,
    parameter int AXIS        = 3,
    parameter int COLORS      = 3,
    parameter int NUM_SAMPLES = 2
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]           color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]             box_R13S;
    logic                                    validTri_R13H;
    logic [3:0]                              subSample_RnnnnU;
    logic                                    halt_RnnnnL;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]           color_R14U;
    logic [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] sample_R14S;
    logic [NUM_SAMPLES-1:0]                  validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_iterator.sv
// Walks a snapped bounding box on the MSAA sub-sample grid, NUM_SAMPLES x-adjacent samples per cycle.
// Optional SAMPLE_ITER_PERF_EN adds accepted-triangle and emitted-sample counters.

// One sample lane: x offset from the row cursor and its in-box test.
module sample_iterator_lane #(
    parameter int SIGFIG = 24,
    parameter int LANE   = 0
) (
    input  logic signed [SIGFIG-1:0] cur_x,
    input  logic signed [SIGFIG-1:0] step,
    input  logic signed [SIGFIG-1:0] ur_x,
    output logic signed [SIGFIG-1:0] samp_x,
    output logic                     samp_vld
);
    localparam logic signed [SIGFIG-1:0] LANE_K = SIGFIG'(LANE);

    always_comb begin
        samp_x   = cur_x + step * LANE_K;
        samp_vld = (samp_x <= ur_x);
    end
endmodule

module sample_iterator #(
    parameter int SIGFIG      = 24,
    parameter int RADIX       = 10,
    parameter int VERTS       = 3,
    parameter int AXIS        = 3,
    parameter int COLORS      = 3,
    parameter int NUM_SAMPLES = 2
) (
    input  logic clk,
    input  logic rst,
    sample_iterator_if.slave bus
`ifdef SAMPLE_ITER_PERF_EN
    ,
    output logic [31:0] triCount_RnnnnU,
    output logic [31:0] sampCount_RnnnnU
`endif
);
    typedef enum logic {WAIT, TEST} state_t;

    localparam logic signed [SIGFIG-1:0] STEP_1X  = SIGFIG'(1 << RADIX);
    localparam logic signed [SIGFIG-1:0] STEP_4X  = SIGFIG'(1 << (RADIX - 1));
    localparam logic signed [SIGFIG-1:0] STEP_16X = SIGFIG'(1 << (RADIX - 2));
    localparam logic signed [SIGFIG-1:0] STEP_64X = SIGFIG'(1 << (RADIX - 3));
    localparam logic signed [SIGFIG-1:0] NS_K     = SIGFIG'(NUM_SAMPLES);

    state_t state, state_nxt;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_q, tri_r14;
    logic [COLORS-1:0][SIGFIG-1:0]           color_q, color_r14;
    logic [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] samp_r14;
    logic [NUM_SAMPLES-1:0]                  vld_r14;

    logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y, step_q, cur_x, cur_y;
    logic signed [SIGFIG-1:0] step_dec, row_adv;
    logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y;
    logic                     accept, box_inv, wrap, last;

    logic [NUM_SAMPLES-1:0][SIGFIG-1:0] lane_x;
    logic [NUM_SAMPLES-1:0]             lane_vld;

    assign in_ll_x = $signed(bus.box_R13S[0][0]);
    assign in_ll_y = $signed(bus.box_R13S[0][1]);
    assign in_ur_x = $signed(bus.box_R13S[1][0]);
    assign in_ur_y = $signed(bus.box_R13S[1][1]);
    assign box_inv = (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);
    assign row_adv = step_q * NS_K;

    always_comb begin
        step_dec = STEP_1X;
        if      (bus.subSample_RnnnnU[3]) step_dec = STEP_1X;
        else if (bus.subSample_RnnnnU[2]) step_dec = STEP_4X;
        else if (bus.subSample_RnnnnU[1]) step_dec = STEP_16X;
        else if (bus.subSample_RnnnnU[0]) step_dec = STEP_64X;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SAMPLES; gi++) begin : g_lane
            sample_iterator_lane #(
                .SIGFIG (SIGFIG),
                .LANE   (gi)
            ) u_lane (
                .cur_x    (cur_x),
                .step     (step_q),
                .ur_x     (ur_x),
                .samp_x   (lane_x[gi]),
                .samp_vld (lane_vld[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT;
        else     state <= state_nxt;
    end

    // Row wraps once the next group would start past ur_x; the last row is the one
    // whose successor would start past ur_y.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wrap      = (cur_x + row_adv) > ur_x;
        last      = wrap && ((cur_y + step_q) > ur_y);
        case (state)
            WAIT: begin
                if (bus.validTri_R13H) begin
                    accept = 1'b1;
                    if (!box_inv) state_nxt = TEST;
                end
            end
            TEST: begin
                if (last) state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tri_q     <= '0;
            color_q   <= '0;
            ll_x      <= '0;
            ll_y      <= '0;
            ur_x      <= '0;
            ur_y      <= '0;
            step_q    <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            tri_r14   <= '0;
            color_r14 <= '0;
            samp_r14  <= '0;
            vld_r14   <= '0;
        end else begin
            vld_r14 <= '0;
            if (accept) begin
                tri_q   <= bus.tri_R13S;
                color_q <= bus.color_R13U;
                ll_x    <= in_ll_x;
                ll_y    <= in_ll_y;
                ur_x    <= in_ur_x;
                ur_y    <= in_ur_y;
                step_q  <= step_dec;
                cur_x   <= in_ll_x;
                cur_y   <= in_ll_y;
            end else if (state == TEST) begin
                tri_r14   <= tri_q;
                color_r14 <= color_q;
                vld_r14   <= lane_vld;
                for (int i = 0; i < NUM_SAMPLES; i++) begin
                    samp_r14[i][0] <= lane_x[i];
                    samp_r14[i][1] <= cur_y;
                end
                if (wrap) begin
                    cur_x <= ll_x;
                    cur_y <= cur_y + step_q;
                end else begin
                    cur_x <= cur_x + row_adv;
                end
            end
        end
    end

    assign bus.halt_RnnnnL    = (state == WAIT);
    assign bus.tri_R14S       = tri_r14;
    assign bus.color_R14U     = color_r14;
    assign bus.sample_R14S    = samp_r14;
    assign bus.validSamp_R14H = vld_r14;

`ifdef SAMPLE_ITER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            triCount_RnnnnU  <= '0;
            sampCount_RnnnnU <= '0;
        end else begin
            if (accept) triCount_RnnnnU <= triCount_RnnnnU + 32'd1;
            sampCount_RnnnnU <= sampCount_RnnnnU + 32'($countones(vld_r14));
        end
    end
`endif

    a_mode_onehot: assert property (@(posedge clk) disable iff (rst)
        accept |-> $onehot(bus.subSample_RnnnnU));
endmodule

// File: tb/tb_sample_iterator.sv
// Randomized + directed bench for sample_iterator against a box-walk scoreboard model.
module tb_sample_iterator;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int NS     = 2;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
    typedef struct packed {
        logic [NS-1:0][SIGFIG-1:0] x;
        logic [SIGFIG-1:0]         y;
        logic [NS-1:0]             v;
        tri_t                      t;
        col_t                      c;
    } emit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_iterator_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS),
                         .COLORS(COLORS), .NUM_SAMPLES(NS)) bus ();

`ifdef SAMPLE_ITER_PERF_EN
    logic [31:0] tri_cnt, samp_cnt;
`endif

    sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
                      .COLORS(COLORS), .NUM_SAMPLES(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SAMPLE_ITER_PERF_EN
        ,
        .triCount_RnnnnU  (tri_cnt),
        .sampCount_RnnnnU (samp_cnt)
`endif
    );

    int    n_chk = 0, n_fail = 0;
    int    cyc = 0, halt_lo = 0, n_emit = 0;
    emit_t exp_q[$];
    int    emit_cyc[$];
    emit_t e;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int step_of(input logic [3:0] m);
        case (m)
            4'b1000: return 1 << RADIX;
            4'b0100: return 1 << (RADIX - 1);
            4'b0010: return 1 << (RADIX - 2);
            default: return 1 << (RADIX - 3);
        endcase
    endfunction

    // Reference: every row from ll_y to ur_y, groups of NS samples from ll_x while the group start is in the box.
    task automatic push_model(input int llx, lly, urx, ury, st, input tri_t t, input col_t c);
        emit_t m;
        for (int y = lly; y <= ury; y += st)
            for (int x = llx; x <= urx; x += NS * st) begin
                for (int i = 0; i < NS; i++) begin
                    m.x[i] = SIGFIG'(x + i * st);
                    m.v[i] = (x + i * st <= urx);
                end
                m.y = SIGFIG'(y);
                m.t = t;
                m.c = c;
                exp_q.push_back(m);
            end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!bus.halt_RnnnnL) halt_lo++;
        if (bus.validSamp_R14H != '0) begin
            n_emit++;
            emit_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("extra_emit", bus.validSamp_R14H, 0);
            else begin
                e = exp_q.pop_front();
                for (int i = 0; i < NS; i++) begin
                    chk("samp_x", bus.sample_R14S[i][0], e.x[i]);
                    chk("samp_y", bus.sample_R14S[i][1], e.y);
                end
                chk("valid", bus.validSamp_R14H, e.v);
                chk("tri", bus.tri_R14S, e.t);
                chk("color", bus.color_R14U, e.c);
            end
        end
    end

    // Presents a triangle, holds it until accepted; hold=1 keeps validTri high afterwards.
    task automatic send(input int llx, lly, urx, ury, input logic [3:0] m, input bit hold);
        tri_t t;
        col_t c;
        int   g = 0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) t[v][a] = SIGFIG'($urandom);
        for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'($urandom);
        bus.tri_R13S         = t;
        bus.color_R13U       = c;
        bus.box_R13S[0][0]   = SIGFIG'(llx);
        bus.box_R13S[0][1]   = SIGFIG'(lly);
        bus.box_R13S[1][0]   = SIGFIG'(urx);
        bus.box_R13S[1][1]   = SIGFIG'(ury);
        bus.subSample_RnnnnU = m;
        bus.validTri_R13H    = 1'b1;
        push_model(llx, lly, urx, ury, step_of(m), t, c);
        while (bus.halt_RnnnnL !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
        if (g >= 1000) chk("send_timeout", bus.halt_RnnnnL, 1);
        @(negedge clk);
        if (!hold) bus.validTri_R13H = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || bus.halt_RnnnnL !== 1'b1) && g < 2000) begin
            @(negedge clk); g++;
        end
        if (g >= 2000) chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int e0, st, llx, lly, urx, ury, idx;
        logic [3:0] m;
        rst = 1'b1;
        bus.validTri_R13H    = 1'b0;
        bus.tri_R13S         = '0;
        bus.color_R13U       = '0;
        bus.box_R13S         = '0;
        bus.subSample_RnnnnU = 4'b1000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_halt", bus.halt_RnnnnL, 1);
        chk("rst_valid", bus.validSamp_R14H, 0);
        chk("rst_samp", bus.sample_R14S, 0);
        chk("rst_tri", bus.tri_R14S, 0);
        chk("rst_color", bus.color_R14U, 0);

        // 1x, 2x2 pixel box
        halt_lo = 0; e0 = n_emit;
        send(0, 0, 2048, 1024, 4'b1000, 1'b0);
        drain();
        chk("s1_halt_lo", halt_lo, 4);
        chk("s1_emits", n_emit - e0, 4);
        chk("s1_hold_valid", bus.validSamp_R14H, 0);
`ifdef SAMPLE_ITER_PERF_EN
        send(0, 0, 2048, 1024, 4'b1000, 1'b0);
        drain();
        chk("perf_tri", tri_cnt, 2);
        chk("perf_samp", samp_cnt, 12);
`endif

        // 4x degenerate box
        halt_lo = 0; e0 = n_emit;
        send(512, 512, 512, 512, 4'b0100, 1'b0);
        drain();
        chk("deg_halt_lo", halt_lo, 1);
        chk("deg_emits", n_emit - e0, 1);

        // 64x single row
        halt_lo = 0; e0 = n_emit;
        send(0, 0, 384, 0, 4'b0001, 1'b0);
        drain();
        chk("r64_halt_lo", halt_lo, 2);
        chk("r64_emits", n_emit - e0, 2);

        // inverted box is swallowed
        halt_lo = 0; e0 = n_emit;
        send(1024, 0, 0, 0, 4'b1000, 1'b0);
        drain();
        chk("inv_halt_lo", halt_lo, 0);
        chk("inv_emits", n_emit - e0, 0);

        // back-to-back with validTri held high: one bubble cycle
        emit_cyc.delete(); e0 = n_emit;
        send(0, 0, 2048, 1024, 4'b1000, 1'b1);
        send(0, 0, 1024, 0, 4'b1000, 1'b0);
        drain();
        chk("b2b_emits", n_emit - e0, 5);
        if (emit_cyc.size() == 5) chk("b2b_gap", emit_cyc[4] - emit_cyc[3], 2);
        else chk("b2b_cyc_count", emit_cyc.size(), 5);

        // reset during the 2nd TEST cycle
        send(0, 0, 2048, 1024, 4'b1000, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_halt", bus.halt_RnnnnL, 1);
        chk("mid_rst_valid", bus.validSamp_R14H, 0);
        chk("mid_rst_samp", bus.sample_R14S, 0);
        chk("mid_rst_tri", bus.tri_R14S, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        halt_lo = 0; e0 = n_emit;
        send(0, 0, 2048, 1024, 4'b1000, 1'b0);
        drain();
        chk("post_rst_halt_lo", halt_lo, 4);
        chk("post_rst_emits", n_emit - e0, 4);

        // random boxes, modes and hold patterns
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 3);
            m   = 4'b1000 >> idx;
            st  = step_of(m);
            llx = (int'($urandom_range(0, 40)) - 20) * st;
            lly = (int'($urandom_range(0, 40)) - 20) * st;
            urx = llx + int'($urandom_range(0, 5)) * st;
            ury = lly + int'($urandom_range(0, 4)) * st;
            if ($urandom_range(0, 9) == 0) urx = llx - st;
            send(llx, lly, urx, ury, m, (n != 39) && ($urandom_range(0, 1) == 1));
        end
        drain();
        chk("q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
